// File: rtl/rs_scheduler_pkg.sv
// Shared sizing defaults and helpers for the reservation-station scheduler.
package rs_scheduler_pkg;

  localparam int RS_SIZE_DEFAULT = 16;
  localparam int ROB_W_DEFAULT   = 4;

  // Index width for an N-entry table; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_rr_select.sv
// Round-robin picker: first set request at or after start_i, wrapping to 0.
module rs_rr_select
  import rs_scheduler_pkg::*;
#(
  parameter int N = RS_SIZE_DEFAULT,
  parameter int W = idx_width(RS_SIZE_DEFAULT)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = (int'(start_i) + i) % N;
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = W'(k);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: free-slot allocation, CDB wakeup and round-robin issue.
module rs_scheduler
  import rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ROB_W   = ROB_W_DEFAULT,
  localparam int IDX_W  = idx_width(RS_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_flag,
  input  logic             alloc_R1,
  input  logic             alloc_R2,
  input  logic [ROB_W-1:0] alloc_Q1,
  input  logic [ROB_W-1:0] alloc_Q2,
  input  logic             alu_cdb_flag,
  input  logic [ROB_W-1:0] alu_cdb_idx,
  input  logic             lsb_cdb_flag,
  input  logic [ROB_W-1:0] lsb_cdb_idx,
  input  logic             alu_accept,
  input  logic             flush,
  output logic [IDX_W-1:0] RS_put_idx_in,
  output logic             RS_full,
  output logic             RS_ready_in,
  output logic [IDX_W-1:0] RS_ready_idx_in
);

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] r1_q, r1_d;
  logic [RS_SIZE-1:0] r2_q, r2_d;
  logic [ROB_W-1:0]   q1_q [RS_SIZE];
  logic [ROB_W-1:0]   q1_d [RS_SIZE];
  logic [ROB_W-1:0]   q2_q [RS_SIZE];
  logic [ROB_W-1:0]   q2_d [RS_SIZE];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0]   put_idx_s;
  logic               full_s;
  logic [RS_SIZE-1:0] issuable_s;
  logic               ready_s;
  logic [IDX_W-1:0]   ready_idx_s;

  function automatic logic cdb_hit(
    input logic [ROB_W-1:0] tag,
    input logic             af,
    input logic [ROB_W-1:0] ai,
    input logic             lf,
    input logic [ROB_W-1:0] li
  );
    return (af && (tag == ai)) || (lf && (tag == li));
  endfunction

  assign full_s     = &valid_q;
  assign issuable_s = valid_q & r1_q & r2_q;

  // Lowest-index free slot; stays 0 when every slot is taken.
  always_comb begin
    put_idx_s = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        put_idx_s = IDX_W'(i);
      end else begin
        put_idx_s = put_idx_s;
      end
    end
  end

  rs_rr_select #(
    .N (RS_SIZE),
    .W (IDX_W)
  ) u_issue_sel (
    .req_i   (issuable_s),
    .start_i (rr_ptr_q),
    .found_o (ready_s),
    .idx_o   (ready_idx_s)
  );

  // Next state: flush dominates; otherwise wakeup, issue and allocate together.
  always_comb begin
    valid_d  = valid_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    q1_d     = q1_q;
    q2_d     = q2_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i] && !r1_q[i] &&
            cdb_hit(q1_q[i], alu_cdb_flag, alu_cdb_idx, lsb_cdb_flag, lsb_cdb_idx)) begin
          r1_d[i] = 1'b1;
        end else begin
          r1_d[i] = r1_q[i];
        end
        if (valid_q[i] && !r2_q[i] &&
            cdb_hit(q2_q[i], alu_cdb_flag, alu_cdb_idx, lsb_cdb_flag, lsb_cdb_idx)) begin
          r2_d[i] = 1'b1;
        end else begin
          r2_d[i] = r2_q[i];
        end
      end
      if (ready_s && alu_accept) begin
        valid_d[ready_idx_s] = 1'b0;
        rr_ptr_d = (ready_idx_s == IDX_W'(RS_SIZE - 1)) ? '0 : ready_idx_s + IDX_W'(1);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      // The alloc slot is free, so it never collides with the issued entry.
      if (alloc_flag && !full_s) begin
        valid_d[put_idx_s] = 1'b1;
        r1_d[put_idx_s] = alloc_R1 ||
          cdb_hit(alloc_Q1, alu_cdb_flag, alu_cdb_idx, lsb_cdb_flag, lsb_cdb_idx);
        r2_d[put_idx_s] = alloc_R2 ||
          cdb_hit(alloc_Q2, alu_cdb_flag, alu_cdb_idx, lsb_cdb_flag, lsb_cdb_idx);
        q1_d[put_idx_s] = alloc_Q1;
        q2_d[put_idx_s] = alloc_Q2;
      end else begin
        valid_d = valid_d;
      end
    end
  end

  // State register: reset wins regardless of rdy; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        q1_q[i] <= '0;
        q2_q[i] <= '0;
      end
    end else if (rdy) begin
      valid_q  <= valid_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      rr_ptr_q <= rr_ptr_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
    end
  end

  assign RS_put_idx_in   = put_idx_s;
  assign RS_full         = full_s;
  assign RS_ready_in     = ready_s;
  assign RS_ready_idx_in = ready_idx_s;

endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 Parameter RS_SIZE, default 16, number of reservation-station entries; index width = `RS_INDEX_RANGE.
REQ-002 Parameter ROB_W, default 4, ROB tag width; matches `ROB_INDEX_RANGE.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; when low, all state holds.
REQ-006 alloc_flag  in  1  dispatch writes a new entry this cycle (dispatch RS_flag).
REQ-007 alloc_R1 / alloc_R2  in  1 each  operand already ready at dispatch.
REQ-008 alloc_Q1 / alloc_Q2  in  ROB_W each  ROB tag awaited when operand not ready.
REQ-009 alu_cdb_flag, alu_cdb_idx  in  1, ROB_W  ALU result broadcast.
REQ-010 lsb_cdb_flag, lsb_cdb_idx  in  1, ROB_W  LSB result broadcast.
REQ-011 alu_accept  in  1  ALU takes the selected entry this cycle.
REQ-012 flush  in  1  branch mispredict clear.
REQ-013 RS_put_idx_in  out  RS_INDEX  free slot for the next allocation (to dispatch).
REQ-014 RS_full  out  1  no free slot; decoder stalls.
REQ-015 RS_ready_in  out  1  at least one entry has both operands ready.
REQ-016 RS_ready_idx_in  out  RS_INDEX  entry selected for issue.

Function
REQ-017 Per entry state: valid, r1, r2 (1 bit each), q1, q2 (ROB_W each); plus round-robin pointer rr_ptr (RS_INDEX).
REQ-018 RS_put_idx_in = lowest-index entry with valid=0, combinational from current state; 0 when RS_full.
REQ-019 RS_full = 1 iff all RS_SIZE entries valid; alloc_flag while RS_full is ignored (no state change).
REQ-020 Entry is issuable iff valid && r1 && r2; RS_ready_in = OR of issuable.
REQ-021 RS_ready_idx_in = first issuable entry searching from rr_ptr upward with wrap to 0; 0 when none.
REQ-022 Issue: RS_ready_in && alu_accept clears valid of RS_ready_idx_in at next edge and sets rr_ptr = RS_ready_idx_in+1 modulo RS_SIZE.
REQ-023 Allocation: alloc_flag && !RS_full writes entry RS_put_idx_in with valid=1, r/q from alloc inputs, visible next cycle; issue of a just-allocated entry occurs no earlier than the following cycle.
REQ-024 Wakeup: each valid entry with r1=0 and q1 equal to an asserted CDB tag sets r1=1; likewise r2/q2; both buses processed in the same cycle.
REQ-025 Same-cycle alloc + CDB: if alloc operand not ready and alloc_Q matches an asserted CDB tag, entry is written with that operand ready.
REQ-026 Same-cycle alloc + issue: both take effect; slots cannot coincide since the alloc slot is free.
REQ-027 flush: all valid cleared, rr_ptr=0 at next edge; overrides alloc, issue and wakeup in the same cycle.
REQ-028 rdy=0: no state change; outputs reflect held state.

Reset
REQ-029 rst=1 at an edge: all valid, r1, r2 = 0, q1, q2 = 0, rr_ptr = 0, independent of rdy.
REQ-030 Post-reset outputs: RS_put_idx_in=0, RS_full=0, RS_ready_in=0, RS_ready_idx_in=0.
REQ-031 Reset asserted mid-operation discards all entries; no issue is signalled in the reset cycle's following state.

Structure
REQ-032 RS_SIZE, `RS_INDEX_RANGE, `ROB_INDEX_RANGE, `TRUE/`FALSE live in define.v; no local redefinition.
REQ-033 One sub-module, rs_rr_select: RS_SIZE-bit request vector + start pointer -> found flag + index; used for issue select (free search uses fixed priority inline).

Verification
REQ-034 Reset, then 16 allocs with alloc_R1=alloc_R2=1 -> RS_put_idx_in 0..15 in order, RS_full=1 after 16th; 17th alloc ignored.
REQ-035 Alloc entry 0 with R1=0,Q1=5; alu_cdb_flag=1, idx=5 next cycle -> RS_ready_in=1, RS_ready_idx_in=0 the cycle after.
REQ-036 Alloc with R2=0,Q2=3 while lsb_cdb_flag=1, idx=3 same cycle -> entry ready on next cycle.
REQ-037 Entries 2,5,9 ready, rr_ptr=6, alu_accept=1 three cycles -> issue order 9, 2, 5; rr_ptr ends at 6.
REQ-038 Full RS, flush and alu_accept asserted together -> next cycle RS_full=0, RS_ready_in=0, RS_put_idx_in=0.
REQ-039 rdy=0 with alloc_flag and CDB active -> no state change; rst=1 with rdy=0 -> state cleared.
